raster_scan_gen: RTL and testbench

Parametrised raster position generator for the VPU pixel pipeline. It replaces the fixed 640×480 pixel counter. It adds configurable blanking intervals, an `active` qualifier, line and frame pulses, a frame counter and a resynchronisation request. It sits between the background FIFO and the pixel compositing stages, and supplies the (x, y) coordinate each stage uses to address sprites and background data.

---
 rtl/vpu_pkg.sv | 21 ++
 rtl/raster_scan_gen_wrap_counter.sv | 36 +++
 rtl/raster_scan_gen.sv | 134 +++++++++++++
 tb/tb_raster_scan_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU definitions: default resolution, scan FSM encoding and
// a width helper used to validate counter widths at elaboration.
package vpu_pkg;

  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_V_ACTIVE = 480;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scanState_e;

  // Number of bits needed to represent maxValue (at least one).
  function automatic int unsigned bitsFor(input int unsigned maxValue);
    int unsigned bits;
    bits = 1;
    while ((maxValue >> bits) != 0) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/raster_scan_gen_wrap_counter.sv
// Modulo-(MAX+1) counter; wrap flags the increment that returns value to 0.
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 639
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] value_q, value_d;

  assign wrap  = inc && (value_q == WIDTH'(MAX));
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = wrap ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/raster_scan_gen.sv
// Raster position generator: (x, y) scan with blanking, active qualifier,
// line/frame pulses, frame counter and resync back to the armed idle state.
module raster_scan_gen
  import vpu_pkg::*;
#(
  parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
  parameter int H_BLANK  = 0,
  parameter int V_BLANK  = 0,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int FCW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           src_ready,
  input  logic           resync,
  output logic [XW-1:0]  pixel_x,
  output logic [YW-1:0]  pixel_y,
  output logic           active,
  output logic           running,
  output logic           line_end,
  output logic           frame_start,
  output logic           frame_done,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;

  if (XW < int'(bitsFor(H_TOTAL - 1))) begin : gXwCheck
    $error("raster_scan_gen: XW too narrow for H_ACTIVE+H_BLANK");
  end
  if (YW < int'(bitsFor(V_TOTAL - 1))) begin : gYwCheck
    $error("raster_scan_gen: YW too narrow for V_ACTIVE+V_BLANK");
  end

  scanState_e     state_q, state_d;
  logic [XW-1:0]  xValue, nextX;
  logic [YW-1:0]  yValue, nextY;
  logic           xInc, xWrap, yWrap, lineWrap, frameWrap, insideNext;
  logic           active_q, active_d;
  logic           lineEnd_q, lineEnd_d;
  logic           frameStart_q, frameStart_d;
  logic           frameDone_q, frameDone_d;
  logic [FCW-1:0] frameCount_q, frameCount_d;

  assign xInc = (state_q == RUN) && enable;

  wrap_counter #(.WIDTH(XW), .MAX(H_TOTAL - 1)) xCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (xInc),
    .clr   (resync),
    .value (xValue),
    .wrap  (xWrap)
  );

  wrap_counter #(.WIDTH(YW), .MAX(V_TOTAL - 1)) yCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (xWrap),
    .clr   (resync),
    .value (yValue),
    .wrap  (yWrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = IDLE;
    end else if (state_q == IDLE && src_ready) begin
      state_d = RUN;
    end
  end

  always_comb begin
    running = (state_q == RUN);
  end

  // Resync suppresses any coincident wrap so a partial frame is never counted.
  always_comb begin
    lineWrap   = xWrap && !resync;
    frameWrap  = xWrap && yWrap && !resync;
    nextX      = xValue;
    nextY      = yValue;
    if (xInc) begin
      nextX = xWrap ? '0 : xValue + 1'b1;
      if (xWrap) begin
        nextY = yWrap ? '0 : yValue + 1'b1;
      end
    end
    insideNext   = (32'(nextX) < H_ACTIVE) && (32'(nextY) < V_ACTIVE);
    active_d     = !resync && ((state_q == RUN) || src_ready) && insideNext;
    lineEnd_d    = lineWrap;
    frameDone_d  = frameWrap;
    frameStart_d = frameWrap || ((state_q == IDLE) && src_ready && !resync);
    frameCount_d = frameWrap ? frameCount_q + 1'b1 : frameCount_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= 1'b0;
      lineEnd_q    <= 1'b0;
      frameStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      frameCount_q <= '0;
    end else begin
      active_q     <= active_d;
      lineEnd_q    <= lineEnd_d;
      frameStart_q <= frameStart_d;
      frameDone_q  <= frameDone_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign pixel_x     = xValue;
  assign pixel_y     = yValue;
  assign active      = active_q;
  assign line_end    = lineEnd_q;
  assign frame_start = frameStart_q;
  assign frame_done  = frameDone_q;
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Scoreboard bench for raster_scan_gen: a small 6x4 configuration and the
// default 640x480 configuration share stimulus, each tracked by its own model.
module tb_raster_scan_gen;

  typedef struct {
    int dut;
    int x;
    int y;
    int active;
    int running;
    int lineEnd;
    int frameStart;
    int frameDone;
    int frameCount;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic srcReady = 1'b0;
  logic resync = 1'b0;

  logic [2:0] sX;
  logic [1:0] sY;
  logic       sActive, sRunning, sLineEnd, sFrameStart, sFrameDone;
  logic [1:0] sCount;

  logic [9:0] dX;
  logic [8:0] dY;
  logic       dActive, dRunning, dLineEnd, dFrameStart, dFrameDone;
  logic [7:0] dCount;

  int hAct[2]  = '{4, 640};
  int hTot[2]  = '{6, 640};
  int vAct[2]  = '{3, 480};
  int vTot[2]  = '{4, 480};
  int fcMod[2] = '{4, 256};

  int mRun[2];
  int mPos[2];
  int mCount[2];

  expT sbQueue[$];
  int  assertCount = 0;
  int  failCount = 0;

  always #5 clk = ~clk;

  raster_scan_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1),
    .XW(3), .YW(2), .FCW(2)
  ) dutSmall (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .src_ready   (srcReady),
    .resync      (resync),
    .pixel_x     (sX),
    .pixel_y     (sY),
    .active      (sActive),
    .running     (sRunning),
    .line_end    (sLineEnd),
    .frame_start (sFrameStart),
    .frame_done  (sFrameDone),
    .frame_count (sCount)
  );

  raster_scan_gen dutDefault (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .src_ready   (srcReady),
    .resync      (resync),
    .pixel_x     (dX),
    .pixel_y     (dY),
    .active      (dActive),
    .running     (dRunning),
    .line_end    (dLineEnd),
    .frame_start (dFrameStart),
    .frame_done  (dFrameDone),
    .frame_count (dCount)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: position kept as a linear index into the frame.
  task automatic modelStep(input int d, input bit en, input bit srdy, input bit rs,
                           input bit r, output expT e);
    int le, fs, fd;
    le = 0; fs = 0; fd = 0;
    if (r) begin
      mRun[d] = 0; mPos[d] = 0; mCount[d] = 0;
    end else if (rs) begin
      mRun[d] = 0; mPos[d] = 0;
    end else if (mRun[d] == 0) begin
      if (srdy) begin
        mRun[d] = 1;
        fs = 1;
      end
    end else if (en) begin
      mPos[d] = (mPos[d] + 1) % (hTot[d] * vTot[d]);
      le = (mPos[d] % hTot[d] == 0) ? 1 : 0;
      fd = (mPos[d] == 0) ? 1 : 0;
      fs = fd;
      if (fd == 1) mCount[d] = (mCount[d] + 1) % fcMod[d];
    end
    e.dut        = d;
    e.x          = mPos[d] % hTot[d];
    e.y          = mPos[d] / hTot[d];
    e.running    = mRun[d];
    e.active     = (mRun[d] == 1 && e.x < hAct[d] && e.y < vAct[d]) ? 1 : 0;
    e.lineEnd    = le;
    e.frameStart = fs;
    e.frameDone  = fd;
    e.frameCount = mCount[d];
  endtask

  task automatic compareAll();
    expT e;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      if (e.dut == 0) begin
        checkOutput("small.x", int'(sX), e.x);
        checkOutput("small.y", int'(sY), e.y);
        checkOutput("small.active", int'(sActive), e.active);
        checkOutput("small.running", int'(sRunning), e.running);
        checkOutput("small.lineEnd", int'(sLineEnd), e.lineEnd);
        checkOutput("small.frameStart", int'(sFrameStart), e.frameStart);
        checkOutput("small.frameDone", int'(sFrameDone), e.frameDone);
        checkOutput("small.frameCount", int'(sCount), e.frameCount);
      end else begin
        checkOutput("dflt.x", int'(dX), e.x);
        checkOutput("dflt.y", int'(dY), e.y);
        checkOutput("dflt.active", int'(dActive), e.active);
        checkOutput("dflt.running", int'(dRunning), e.running);
        checkOutput("dflt.lineEnd", int'(dLineEnd), e.lineEnd);
        checkOutput("dflt.frameStart", int'(dFrameStart), e.frameStart);
        checkOutput("dflt.frameDone", int'(dFrameDone), e.frameDone);
        checkOutput("dflt.frameCount", int'(dCount), e.frameCount);
      end
    end
  endtask

  task automatic applyStimulus(input bit en, input bit srdy, input bit rs, input bit r);
    expT e;
    enable   = en;
    srcReady = srdy;
    resync   = rs;
    rst      = r;
    for (int d = 0; d < 2; d++) begin
      modelStep(d, en, srdy, rs, r, e);
      sbQueue.push_back(e);
    end
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    int leCount, fdCount, inactiveCount;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Idle: src_ready low keeps the generator parked even with enable high.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    leCount = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      leCount += int'(sLineEnd);
    end
    checkOutput("frame1.lineEndCount", leCount, 4);
    checkOutput("frame1.frameDoneLast", int'(sFrameDone), 1);
    checkOutput("frame1.count", int'(sCount), 1);

    fdCount = 0;
    for (int i = 0; i < 48; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 1'b0, 1'b0);
      fdCount += int'(sFrameDone);
    end
    checkOutput("toggle.frameDoneCount", fdCount, 1);
    checkOutput("toggle.count", int'(sCount), 2);

    for (int i = 0; i < 96; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fourFrames.countWrapped", int'(sCount), 2);

    // Resync mid-frame at (3,2), then idle behaviour and re-arm.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resync.atX", int'(sX), 3);
    checkOutput("resync.atY", int'(sY), 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Resync coincident with the frame wrap at (5,3).
    for (int i = 0; i < 23; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("resyncWrap.frameDone", int'(sFrameDone), 0);
    checkOutput("resyncWrap.count", int'(sCount), 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-line with enable high.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("midReset.running", int'(sRunning), 0);

    // Zero-blanking default geometry: visible throughout and wraps at 639.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    leCount = 0;
    inactiveCount = 0;
    for (int i = 0; i < 1300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      leCount += int'(dLineEnd);
      if (dActive == 1'b0) inactiveCount++;
      if (i == 638) checkOutput("dflt.lastX", int'(dX), 639);
    end
    checkOutput("dflt.lineEndCount", leCount, 2);
    checkOutput("dflt.inactiveCount", inactiveCount, 0);

    for (int i = 0; i < 200; i++) applyStimulus(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
